pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 50 +++++
 rtl/pipe_slot.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// occupancy state encoding and the per-stage bundle layouts.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_t;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  aluOp;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } id_ex_bundle_t;

    typedef struct packed {
        logic [31:0] aluRes;
        logic [31:0] storeVal;
        logic [4:0]  rd;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } ex_mem_bundle_t;

    typedef struct packed {
        logic [31:0] wbVal;
        logic [4:0]  rd;
        logic        regWrite;
    } mem_wb_bundle_t;

    localparam int IF_ID_W  = $bits(if_id_bundle_t);
    localparam int ID_EX_W  = $bits(id_ex_bundle_t);
    localparam int EX_MEM_W = $bits(ex_mem_bundle_t);
    localparam int MEM_WB_W = $bits(mem_wb_bundle_t);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a data word plus its valid bit, with load and
// clear-to-bubble controls. An empty slot always presents RESET_VAL.
module pipe_slot #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] dIn,
    output logic             valid,
    output logic [WIDTH-1:0] dOut
);

    logic             validQ;
    logic [WIDTH-1:0] dataQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validQ <= 1'b0;
        end else if (clear) begin
            validQ <= 1'b0;
        end else if (load) begin
            validQ <= 1'b1;
        end
    end

    // Data needs no reset: the output mux below hides it until valid.
    always_ff @(posedge clk) begin
        if (clear) begin
            dataQ <= RESET_VAL;
        end else if (load) begin
            dataQ <= dIn;
        end
    end

    assign valid = validQ;
    assign dOut  = validQ ? dataQ : RESET_VAL;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with synchronous flush and an
// optional two-entry skid buffer that makes in_ready a registered signal.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    logic             push;
    logic             pop;
    logic             mainLoad;
    logic             mainClear;
    logic             mainValid;
    logic [WIDTH-1:0] mainIn;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = mainValid;

    pipe_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) uMain (
        .clk   (clk),
        .rst   (rst),
        .load  (mainLoad),
        .clear (mainClear),
        .dIn   (mainIn),
        .valid (mainValid),
        .dOut  (out_data)
    );

    generate
        if (SKID == 0) begin : gSingle
            assign in_ready  = rst & ~flush & (~mainValid | out_ready);
            assign mainLoad  = push;
            assign mainClear = flush | (pop & ~push);
            assign mainIn    = in_data;
            assign count     = {1'b0, mainValid};
        end else begin : gSkid
            stage_st_t        state;
            logic             readyQ;
            logic             skidLoad;
            logic             skidClear;
            logic             skidValid;
            logic [WIDTH-1:0] skidData;

            pipe_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) uSkid (
                .clk   (clk),
                .rst   (rst),
                .load  (skidLoad),
                .clear (skidClear),
                .dIn   (in_data),
                .valid (skidValid),
                .dOut  (skidData)
            );

            // readyQ resets high so the stage accepts right after release;
            // the rst term keeps it low while reset is asserted.
            assign in_ready = rst & ~flush & readyQ;

            always_comb begin
                mainLoad  = 1'b0;
                mainClear = flush;
                mainIn    = in_data;
                skidLoad  = 1'b0;
                skidClear = flush;
                if (!flush) begin
                    case (state)
                        ST_EMPTY: mainLoad = push;
                        ST_ONE: begin
                            if (push && pop) begin
                                mainLoad = 1'b1;
                            end else if (push) begin
                                skidLoad = 1'b1;
                            end else if (pop) begin
                                mainClear = 1'b1;
                            end
                        end
                        ST_FULL: begin
                            if (pop) begin
                                mainLoad  = 1'b1;
                                mainIn    = skidData;
                                skidClear = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state  <= ST_EMPTY;
                    readyQ <= 1'b1;
                end else if (flush) begin
                    state  <= ST_EMPTY;
                    readyQ <= 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: if (push) state <= ST_ONE;
                        ST_ONE: begin
                            if (push && !pop) begin
                                state  <= ST_FULL;
                                readyQ <= 1'b0;
                            end else if (pop && !push) begin
                                state <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (pop) begin
                                state  <= ST_ONE;
                                readyQ <= 1'b1;
                            end
                        end
                        default: begin
                            state  <= ST_EMPTY;
                            readyQ <= 1'b1;
                        end
                    endcase
                end
            end

            assign count = {1'b0, mainValid} + {1'b0, skidValid};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table for both modes, then
// randomized traffic against a queue-based occupancy model.
module tb_pipe_stage_reg;

    logic       clk;
    logic       rst0, flush0, iv0, ir0, ov0, or0;
    logic [7:0] id0, od0;
    logic [1:0] cnt0;
    logic       rst1, flush1, iv1, ir1, ov1, or1;
    logic [7:0] id1, od1;
    logic [1:0] cnt1;

    pipe_stage_reg #(.WIDTH(8), .SKID(0), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst0), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
        .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .count(cnt0)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID(1), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .rst(rst1), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       skid;
        logic       rstN;
        logic       flush;
        logic       inValid;
        logic [7:0] inData;
        logic       outReady;
        logic       expValid;
        logic [7:0] expData;
        logic [1:0] expCount;
        logic       expReady;
    } vec_t;

    int nTests = 0;
    int nFail  = 0;
    vec_t vecs[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic f, input logic iv,
                                input logic [7:0] d, input logic orr, input logic ev,
                                input logic [7:0] ed, input logic [1:0] ec, input logic er);
        vec_t v;
        v.skid = s; v.rstN = r; v.flush = f; v.inValid = iv; v.inData = d;
        v.outReady = orr; v.expValid = ev; v.expData = ed; v.expCount = ec; v.expReady = er;
        return v;
    endfunction

    task automatic applyVec(input vec_t v, input int idx);
        @(negedge clk);
        if (!v.skid) begin
            rst0 = v.rstN; flush0 = v.flush; iv0 = v.inValid; id0 = v.inData; or0 = v.outReady;
            flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
        end else begin
            rst1 = v.rstN; flush1 = v.flush; iv1 = v.inValid; id1 = v.inData; or1 = v.outReady;
            flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b0;
        end
        #1;
        if (!v.skid) begin
            chk($sformatf("vec%0d out_valid", idx), {7'b0, ov0}, {7'b0, v.expValid});
            chk($sformatf("vec%0d out_data", idx), od0, v.expData);
            chk($sformatf("vec%0d count", idx), {6'b0, cnt0}, {6'b0, v.expCount});
            chk($sformatf("vec%0d in_ready", idx), {7'b0, ir0}, {7'b0, v.expReady});
        end else begin
            chk($sformatf("vec%0d out_valid", idx), {7'b0, ov1}, {7'b0, v.expValid});
            chk($sformatf("vec%0d out_data", idx), od1, v.expData);
            chk($sformatf("vec%0d count", idx), {6'b0, cnt1}, {6'b0, v.expCount});
            chk($sformatf("vec%0d in_ready", idx), {7'b0, ir1}, {7'b0, v.expReady});
        end
    endtask

    initial begin
        rst0 = 1'b0; flush0 = 1'b0; iv0 = 1'b0; id0 = 8'h00; or0 = 1'b0;
        rst1 = 1'b0; flush1 = 1'b0; iv1 = 1'b0; id1 = 8'h00; or1 = 1'b0;

        // SKID=0: reset, streaming, pop to bubble, stall, mid-stream reset, flush
        //                 s  r  f  iv d      or ev ed     ec    er
        vecs.push_back(mk(0, 0, 0, 1, 8'h11, 1, 0, 8'h00, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h11, 1, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'h22, 1, 1, 8'h11, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'h33, 1, 1, 8'h22, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 8'h33, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'hA5, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'h5A, 0, 1, 8'hA5, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h5A, 0, 1, 8'hA5, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h5A, 0, 1, 8'hA5, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h5A, 1, 1, 8'hA5, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 8'h5A, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'h99, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'h98, 0, 0, 8'h00, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 8'h44, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 8'h55, 1, 1, 8'h44, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 1));
        // SKID=1: reset, fill/drain, streaming, flush from FULL and from ONE
        vecs.push_back(mk(1, 0, 0, 1, 8'h01, 0, 0, 8'h00, 2'd0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 8'h01, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 8'h02, 0, 1, 8'h01, 2'd1, 1));
        vecs.push_back(mk(1, 1, 0, 1, 8'h03, 0, 1, 8'h01, 2'd2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 1, 1, 8'h01, 2'd2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 1, 1, 8'h02, 2'd1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 8'h11, 1, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 8'h22, 1, 1, 8'h11, 2'd1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 1, 1, 8'h22, 2'd1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 8'h0A, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 8'h0B, 0, 1, 8'h0A, 2'd1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 8'h77, 0, 1, 8'h0A, 2'd2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 1, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 8'h0C, 0, 0, 8'h00, 2'd0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 8'h0D, 1, 1, 8'h0C, 2'd1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 1));

        for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

        // Randomized traffic on both instances against a queue model
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b0; or1 = 1'b0;
        q0.delete(); q1.delete();
        for (int c = 0; c < 3000; c++) begin
            logic ev0, er0, push0, pop0;
            logic ev1, er1, push1, pop1;
            logic [7:0] ed0, ed1;
            @(negedge clk);
            rst0   = ($urandom_range(0, 99) != 0);
            flush0 = ($urandom_range(0, 15) == 0);
            iv0    = 1'($urandom_range(0, 1));
            id0    = 8'($urandom);
            or0    = ($urandom_range(0, 3) != 0);
            rst1   = ($urandom_range(0, 99) != 0);
            flush1 = ($urandom_range(0, 15) == 0);
            iv1    = ($urandom_range(0, 3) != 0);
            id1    = 8'($urandom);
            or1    = 1'($urandom_range(0, 1));
            #1;
            if (!rst0) q0.delete();
            if (!rst1) q1.delete();
            ev0 = (q0.size() != 0);
            ed0 = ev0 ? q0[0] : 8'h00;
            er0 = rst0 & ~flush0 & ((q0.size() == 0) | or0);
            ev1 = (q1.size() != 0);
            ed1 = ev1 ? q1[0] : 8'h00;
            er1 = rst1 & ~flush1 & (q1.size() < 2);
            chk("rnd0 out_valid", {7'b0, ov0}, {7'b0, ev0});
            chk("rnd0 out_data", od0, ed0);
            chk("rnd0 count", {6'b0, cnt0}, 8'(q0.size()));
            chk("rnd0 in_ready", {7'b0, ir0}, {7'b0, er0});
            chk("rnd1 out_valid", {7'b0, ov1}, {7'b0, ev1});
            chk("rnd1 out_data", od1, ed1);
            chk("rnd1 count", {6'b0, cnt1}, 8'(q1.size()));
            chk("rnd1 in_ready", {7'b0, ir1}, {7'b0, er1});
            push0 = iv0 & er0; pop0 = ev0 & or0;
            push1 = iv1 & er1; pop1 = ev1 & or1;
            @(posedge clk);
            if (rst0) begin
                if (flush0) q0.delete();
                else begin
                    if (pop0) void'(q0.pop_front());
                    if (push0) q0.push_back(id0);
                end
            end
            if (rst1) begin
                if (flush1) q1.delete();
                else begin
                    if (pop1) void'(q1.pop_front());
                    if (push1) q1.push_back(id1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
